// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the fetch-stage next-PC generator and its BTB.
package pc_gen_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    CtrSnt = 2'b00,
    CtrWnt = 2'b01,
    CtrWt  = 2'b10,
    CtrSt  = 2'b11
  } ctr_e;

  // Tag and target are stored at full default width; narrower tags are zero-extended.
  typedef struct packed {
    logic                valid;
    logic [XLEN_DEF-1:0] tag;
    logic [XLEN_DEF-1:0] target;
    ctr_e                ctr;
  } btb_entry_t;

  function automatic ctr_e ctr_next(ctr_e cur, logic taken);
    ctr_e nxt;
    nxt = cur;
    if (taken) begin
      if (cur != CtrSt) nxt = ctr_e'(cur + 2'b01);
    end else begin
      if (cur != CtrSnt) nxt = ctr_e'(cur - 2'b01);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, registered update/allocation.
module pc_btb
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-3:0] lookup_word,
  output logic            hit_taken,
  output logic [XLEN-1:0] hit_target,
  input  logic            upd_valid,
  input  logic [XLEN-3:0] upd_word,
  input  logic            upd_taken,
  input  logic            upd_is_br,
  input  logic [XLEN-1:0] upd_target
);

  localparam int unsigned IDX = $clog2(BTB_DEPTH);

  btb_entry_t entries_q [BTB_DEPTH];

  logic [IDX-1:0]      rd_idx, wr_idx;
  logic [XLEN_DEF-1:0] rd_tag, wr_tag;
  btb_entry_t          rd_entry, old_entry, new_entry;
  logic                upd_hit, wr_en;

  assign rd_idx   = lookup_word[IDX-1:0];
  assign rd_tag   = XLEN_DEF'(lookup_word[XLEN-3:IDX]);
  assign rd_entry = entries_q[rd_idx];

  assign hit_taken  = rd_entry.valid && (rd_entry.tag == rd_tag) && rd_entry.ctr[1];
  assign hit_target = rd_entry.target[XLEN-1:0];

  assign wr_idx    = upd_word[IDX-1:0];
  assign wr_tag    = XLEN_DEF'(upd_word[XLEN-3:IDX]);
  assign old_entry = entries_q[wr_idx];
  assign upd_hit   = old_entry.valid && (old_entry.tag == wr_tag);

  always_comb begin
    wr_en     = 1'b0;
    new_entry = old_entry;
    if (upd_valid) begin
      if (upd_hit) begin
        wr_en         = 1'b1;
        new_entry.ctr = ctr_next(old_entry.ctr, upd_taken);
        if (upd_taken) new_entry.target = XLEN_DEF'(upd_target);
      end else if (upd_taken) begin
        // Cold allocation: unconditional jumps start strongly taken, branches weakly.
        wr_en            = 1'b1;
        new_entry.valid  = 1'b1;
        new_entry.tag    = wr_tag;
        new_entry.target = XLEN_DEF'(upd_target);
        new_entry.ctr    = upd_is_br ? CtrWt : CtrSt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < int'(BTB_DEPTH); i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else if (wr_en) begin
      entries_q[wr_idx] <= new_entry;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register, mispredict redirect and perf counters.
// Define PC_GEN_BTB_EN to add the BTB predictor; otherwise fetch is static not-taken.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEF,
  parameter int unsigned     BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall_if,
  input  logic            ex_valid,
  input  logic            ex_is_br,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            redirect,
  output logic [31:0]     br_cnt,
  output logic [31:0]     miss_cnt
);

  if (BTB_DEPTH < 2 || (BTB_DEPTH & (BTB_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_gen: BTB_DEPTH must be a power of 2 and at least 2");
  end

  logic [XLEN-1:0] pc_q, pc_d, pc_plus4, correct_pc;
  logic [31:0]     br_cnt_q, miss_cnt_q;
  logic            actual_taken;

  assign pc_plus4     = pc_q + XLEN'(4);
  assign actual_taken = ex_is_jal | ex_is_jalr | (ex_is_br & ex_taken);
  assign correct_pc   = actual_taken ? ex_target : ex_pc + XLEN'(4);
  assign redirect     = ex_valid & ((actual_taken != ex_pred_taken) |
                                    (actual_taken & (ex_target != ex_pred_target)));

`ifdef PC_GEN_BTB_EN
  logic            btb_hit_taken;
  logic [XLEN-1:0] btb_hit_target;

  pc_btb #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk         (clk),
    .rstn        (rstn),
    .lookup_word (pc_q[XLEN-1:2]),
    .hit_taken   (btb_hit_taken),
    .hit_target  (btb_hit_target),
    .upd_valid   (ex_valid),
    .upd_word    (ex_pc[XLEN-1:2]),
    .upd_taken   (actual_taken),
    .upd_is_br   (ex_is_br),
    .upd_target  (ex_target)
  );

  assign pred_taken  = btb_hit_taken;
  assign pred_target = btb_hit_taken ? btb_hit_target : pc_plus4;
`else
  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;
`endif

  // Redirect wins over a stall so the flushed path never keeps fetching.
  always_comb begin
    pc_d = pc_plus4;
    if (redirect)        pc_d = correct_pc;
    else if (stall_if)   pc_d = pc_q;
    else if (pred_taken) pc_d = pred_target;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q       <= RESET_PC;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (ex_valid) br_cnt_q <= br_cnt_q + 32'd1;
      if (redirect) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign pc       = pc_q;
  assign br_cnt   = br_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule
